// File: rtl/psl_ccreg_if.sv
// Flag/bus bundle between the ALU datapath and the PSL condition-code register.
// The master drives the flags and the microcode controls. The slave returns the CC state.
interface psl_ccreg_if;
    logic [2:0]  ccctl_h;
    logic [1:0]  dsize_h;
    logic        double_enable_h;
    logic        alu_c31_l;
    logic        alu_c15_l;
    logic        alu_c7_l;
    logic        alu_v31_h;
    logic        alu_v15_h;
    logic        alu_v7_h;
    logic [3:0]  wmuxz_h;
    logic [31:0] wbus_h;
    logic        psl_iv_h;
    logic        trap_ack_h;
    logic [3:0]  psl_cc_h;
    logic [3:0]  alu_cc_h;
    logic        pslc_h;
    logic        iov_trap_h;
    logic        dbl_half_h;

    modport master (
        output ccctl_h, dsize_h, double_enable_h,
        output alu_c31_l, alu_c15_l, alu_c7_l,
        output alu_v31_h, alu_v15_h, alu_v7_h,
        output wmuxz_h, wbus_h, psl_iv_h, trap_ack_h,
        input  psl_cc_h, alu_cc_h, pslc_h, iov_trap_h, dbl_half_h
    );

    modport slave (
        input  ccctl_h, dsize_h, double_enable_h,
        input  alu_c31_l, alu_c15_l, alu_c7_l,
        input  alu_v31_h, alu_v15_h, alu_v7_h,
        input  wmuxz_h, wbus_h, psl_iv_h, trap_ack_h,
        output psl_cc_h, alu_cc_h, pslc_h, iov_trap_h, dbl_half_h
    );
endinterface

// File: rtl/psl_ccreg.sv
// Condition-code register: size-selected NZVC, quad zero merge across two halves,
// ALU-CC and PSL NZVC update under microcode control, and a sticky integer-overflow trap.
module psl_ccreg (
    input  logic              qd_clk_l,
    input  logic              reset_l,
    psl_ccreg_if.slave        bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HALF = 1'b1
    } state_e;

    localparam logic [2:0] CC_HOLD   = 3'b000;
    localparam logic [2:0] CC_ALU    = 3'b001;
    localparam logic [2:0] CC_BOTH   = 3'b010;
    localparam logic [2:0] CC_KEEPC  = 3'b011;
    localparam logic [2:0] CC_CLRV   = 3'b100;
    localparam logic [2:0] CC_LOAD   = 3'b101;
    localparam logic [2:0] CC_COMMIT = 3'b110;
    localparam logic [2:0] CC_CLEAR  = 3'b111;

    state_e     state_q, state_d;
    logic       zlo_q, zlo_d;
    logic [3:0] alu_cc_q, alu_cc_d;
    logic [3:0] psl_cc_q, psl_cc_d;
    logic       iov_q, iov_d;

    logic       n_flag, z_flag, v_flag, c_flag;
    logic       z_eff;
    logic [3:0] flags;
    logic       alu_op;
    logic       first_half;
    logic       trap_set;

    // NOTE: every always_comb output gets a value before any branch, so no path can leave it unassigned and infer a latch.
    always_comb begin
        n_flag = bus.wbus_h[31];
        z_flag = &bus.wmuxz_h;
        v_flag = bus.alu_v31_h;
        c_flag = ~bus.alu_c31_l;
        case (bus.dsize_h)
            2'b00: begin
                n_flag = bus.wbus_h[7];
                z_flag = bus.wmuxz_h[0];
                v_flag = bus.alu_v7_h;
                c_flag = ~bus.alu_c7_l;
            end
            2'b01: begin
                n_flag = bus.wbus_h[15];
                z_flag = &bus.wmuxz_h[1:0];
                v_flag = bus.alu_v15_h;
                c_flag = ~bus.alu_c15_l;
            end
            default: ;
        endcase
    end

    assign alu_op     = (bus.ccctl_h inside {CC_ALU, CC_BOTH, CC_KEEPC, CC_CLRV});
    assign first_half = (state_q == IDLE) && bus.double_enable_h && alu_op;
    // The second half of a quad sees only the high longword's zero. The low half was latched into zlo.
    assign z_eff      = (state_q == HALF) ? (z_flag & zlo_q) : z_flag;
    assign flags      = {n_flag, z_eff, v_flag, c_flag};

    always_comb begin
        state_d  = IDLE;
        zlo_d    = 1'b0;
        alu_cc_d = alu_cc_q;
        psl_cc_d = psl_cc_q;
        trap_set = 1'b0;

        if (first_half) begin
            state_d = HALF;
            zlo_d   = z_flag;
        end else begin
            case (bus.ccctl_h)
                CC_HOLD: ;
                CC_ALU: alu_cc_d = flags;
                CC_BOTH: begin
                    alu_cc_d = flags;
                    psl_cc_d = flags;
                    trap_set = v_flag & bus.psl_iv_h;
                end
                CC_KEEPC: begin
                    alu_cc_d = flags;
                    psl_cc_d = {flags[3:1], psl_cc_q[0]};
                    trap_set = v_flag & bus.psl_iv_h;
                end
                CC_CLRV: begin
                    alu_cc_d = flags;
                    psl_cc_d = {flags[3:2], 1'b0, psl_cc_q[0]};
                end
                CC_LOAD:   psl_cc_d = bus.wbus_h[3:0];
                CC_COMMIT: psl_cc_d = alu_cc_q;
                CC_CLEAR:  psl_cc_d = 4'b0000;
            endcase
        end

        // A new overflow in the same cycle as an acknowledge must not be lost.
        iov_d = trap_set | (iov_q & ~bus.trap_ack_h);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the pre-edge values together.
    always_ff @(posedge qd_clk_l or negedge reset_l) begin
        if (!reset_l) begin
            state_q  <= IDLE;
            zlo_q    <= 1'b0;
            alu_cc_q <= 4'b0000;
            psl_cc_q <= 4'b0000;
            iov_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            zlo_q    <= zlo_d;
            alu_cc_q <= alu_cc_d;
            psl_cc_q <= psl_cc_d;
            iov_q    <= iov_d;
        end
    end

    assign bus.psl_cc_h   = psl_cc_q;
    assign bus.alu_cc_h   = alu_cc_q;
    assign bus.pslc_h     = psl_cc_q[0];
    assign bus.iov_trap_h = iov_q;
    assign bus.dbl_half_h = (state_q == HALF);

endmodule

// File: doc/psl_ccreg.md
Name: psl_ccreg

Overview:
- Condition-code register at the consuming end of the ALU datapath flag outputs.
- Each microcycle it:
  - selects carry, overflow, zero and sign by data size;
  - merges the zero flag across the two halves of a double-clocked (quad) operation;
  - updates the ALU-CC and PSL NZVC registers under microcode control.
- Returns the registered PSL C bit (pslc_h) to the ALU control logic.
- Raises a sticky integer-overflow trap request.

Parameters:
- none

Ports:
- qd_clk_l  in  1  clock; all registers update on its rising edge
- reset_l  in  1  asynchronous active-low reset
- ccctl_h  in  3  microcode CC control (encodings below)
- dsize_h  in  2  00 byte, 01 word, 10 long, 11 quad
- double_enable_h  in  1  high in first cycle of a two-cycle (quad) ALU operation
- alu_c31_l, alu_c15_l, alu_c7_l  in  1 each  ALU carry-outs, active low
- alu_v31_h, alu_v15_h, alu_v7_h  in  1 each  ALU overflows
- wmuxz_h  in  4  per-byte zero flags; bit i = wbus byte i is zero
- wbus_h  in  32  write bus (sign bits; PSL load data)
- psl_iv_h  in  1  PSL integer-overflow trap enable
- trap_ack_h  in  1  clears iov_trap_h
- psl_cc_h  out  4  PSL {N,Z,V,C}
- alu_cc_h  out  4  ALU CC {N,Z,V,C} for microbranching
- pslc_h  out  1  equals psl_cc_h[0]
- iov_trap_h  out  1  sticky overflow trap request
- dbl_half_h  out  1  high while in state HALF

Behaviour:
Computed flags (combinational, from the current cycle):
- byte: N=wbus_h[7], Z=wmuxz_h[0], V=alu_v7_h, C=~alu_c7_l
- word: N=wbus_h[15], Z=&wmuxz_h[1:0], V=alu_v15_h, C=~alu_c15_l
- long/quad: N=wbus_h[31], Z=&wmuxz_h, V=alu_v31_h, C=~alu_c31_l

Double-half state machine, states IDLE / HALF:
- IDLE with double_enable_h=1 and an ALU-derived ccctl (001-100):
  - next state HALF; zlo <= Z;
  - alu_cc and psl_cc hold (first half updates nothing).
- HALF, any input: next state IDLE.
  - Effective Z = Z & zlo; N, V, C come from the second cycle.
- double_enable_h while in HALF is ignored.
- Non-ALU ccctl (000, 101-111) never enters HALF.

ccctl_h encodings (effective Z applied where Z is used):
- 000 hold
- 001 alu_cc <= computed; psl hold
- 010 alu_cc and psl_cc <= {N,Z,V,C}
- 011 alu_cc <= computed; psl N,Z,V <= computed; psl C preserved
- 100 alu_cc <= computed; psl <= {N,Z,0,C_old}
- 101 psl_cc <= wbus_h[3:0]; alu_cc hold
- 110 psl_cc <= alu_cc (commit)
- 111 psl_cc <= 0000

Rules for 101-111:
- Take effect in the same cycle regardless of state.
- In HALF: state still returns to IDLE and zlo is discarded.

Trap:
- iov_trap_h sets when ccctl is 010 or 011, computed V=1, psl_iv_h=1, and the update actually occurs (i.e. not a first half).
- Clears on trap_ack_h.
- Set and ack in the same cycle: set wins.

Timing:
- pslc_h = psl_cc_h[0]; one cycle latency from flag inputs to all outputs.

Reset (asynchronous, any time, including mid-double):
- psl_cc_h, alu_cc_h, pslc_h, iov_trap_h, zlo = 0
- state = IDLE; dbl_half_h = 0

Test Plan:
- Byte load: dsize=00, ccctl=010, wbus=0x00000080, wmuxz=1110, alu_c7_l=0, alu_v7_h=0 -> psl_cc=1001, alu_cc=1001, pslc_h=1.
- C preserved / MOV:
  - Preset psl C=1 via ccctl=101, wbus=0x1.
  - ccctl=011, long, wbus=0, wmuxz=1111, alu_v31_h=1, alu_c31_l=1 -> psl_cc=0111.
  - Then ccctl=100, same inputs -> psl_cc=0101.
- Quad Z merge:
  - Cycle1: double_enable_h=1, ccctl=010, wmuxz=1111 -> outputs hold, dbl_half_h=1.
  - Cycle2: wmuxz=0111 -> Z=0.
  - Repeat with both halves zero -> Z=1.
- Overflow trap:
  - psl_iv_h=1, ccctl=010, long, alu_v31_h=1 -> iov_trap_h=1.
  - trap_ack_h alone -> 0.
  - Ack coincident with new overflow -> stays 1.
  - With psl_iv_h=0 -> stays 0.
- Commit / clear:
  - ccctl=001 with flags 1010 -> alu_cc=1010, psl unchanged.
  - ccctl=110 -> psl_cc=1010.
  - ccctl=111 -> psl_cc=0000.
- Reset in HALF: assert reset_l=0 between the halves -> all outputs 0 and dbl_half_h=0 immediately; next ccctl=010 without double_enable_h updates normally.
